reorder_buffer: RTL and testbench

- Circular reorder buffer that allocates rename tags at issue and retires results in program order.
- Captures execution results from the common data bus (CDB).
- Drives the commit port (rob_commit_signal / commit_rd_value / commit_rd_tag) that the register file consumes.
- Offers tag-indexed operand lookup so issue logic can resolve operands that are still in flight.
- Sits between the instruction latch/issue stage, the execution units' CDB and register_file.

---
 rtl/reorder_buffer_pkg.sv | 16 +
 rtl/reorder_buffer_query_port.sv | 37 +++
 rtl/reorder_buffer.sv | 112 +++++++++++
 tb/tb_reorder_buffer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: the data width, the
// architectural register count, the default tag width and the per-entry record.
package reorder_buffer_pkg;

    localparam int REG_WIDTH         = 32;
    localparam int REG_SIZE          = 32;
    localparam int ROB_WIDTH_DEFAULT = 4;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        logic [REG_WIDTH-1:0] rd_id;
        logic [REG_WIDTH-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_query_port.sv
// rob_query_port: combinational tag-indexed operand lookup into the ROB.
// With ROB_QUERY_BYPASS_EN defined, a same-cycle CDB write to the queried busy entry is forwarded.
module rob_query_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  rob_entry_t           i_entries [2**ROB_WIDTH],
    input  logic [ROB_WIDTH-1:0] i_query_tag,
    input  logic                 i_cdb_signal,
    input  logic [ROB_WIDTH-1:0] i_cdb_tag,
    input  logic [REG_WIDTH-1:0] i_cdb_value,
    output logic                 o_query_ready,
    output logic [REG_WIDTH-1:0] o_query_value
);

    rob_entry_t w_entry;

    always_comb begin
        w_entry       = i_entries[i_query_tag];
        o_query_ready = w_entry.busy & w_entry.ready;
        o_query_value = w_entry.value;
`ifdef ROB_QUERY_BYPASS_EN
        if (i_cdb_signal && (i_cdb_tag == i_query_tag) && w_entry.busy) begin
            o_query_ready = 1'b1;
            o_query_value = i_cdb_value;
        end
`endif
    end

`ifndef ROB_QUERY_BYPASS_EN
    // CDB inputs only matter when forwarding is built in.
    logic w_unused_cdb;
    assign w_unused_cdb = ^{i_cdb_signal, i_cdb_tag, i_cdb_value};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results, retires in order.
// Optional macro ROB_QUERY_BYPASS_EN enables CDB-to-query forwarding in rob_query_port.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [REG_WIDTH-1:0] issue_rd_id,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic                 cdb_signal,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [REG_WIDTH-1:0] cdb_value,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [REG_WIDTH-1:0] query_value_1,
    output logic [REG_WIDTH-1:0] query_value_2,
    output logic                 rob_commit_signal,
    output logic [REG_WIDTH-1:0] commit_rd_value,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic [REG_WIDTH-1:0] commit_rd_id
);

    localparam int DEPTH = 2**ROB_WIDTH;

    rob_entry_t           r_entries [DEPTH];
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;

    rob_entry_t w_head_entry;
    logic       w_full;
    logic       w_issue;
    logic       w_commit;
    logic       w_wb;

    assign w_head_entry = r_entries[r_head];
    assign w_full       = (r_count == (ROB_WIDTH+1)'(DEPTH));
    assign w_issue      = issue_signal & ~w_full;
    assign w_commit     = w_head_entry.busy & w_head_entry.ready;
    assign w_wb         = cdb_signal & r_entries[cdb_tag].busy;

    assign rob_full  = w_full;
    assign issue_tag = r_tail;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            rob_commit_signal <= 1'b0;
            commit_rd_value   <= '0;
            commit_rd_tag     <= '0;
            commit_rd_id      <= '0;
        end else if (rdy_in) begin
            if (w_wb) begin
                r_entries[cdb_tag].ready <= 1'b1;
                r_entries[cdb_tag].value <= cdb_value;
            end
            rob_commit_signal <= w_commit;
            if (w_commit) begin
                r_entries[r_head].busy <= 1'b0;
                r_head                 <= r_head + 1'b1;
                commit_rd_value        <= w_head_entry.value;
                commit_rd_tag          <= r_head;
                commit_rd_id           <= w_head_entry.rd_id;
            end
            // The tail slot is never busy when issue is accepted, so this cannot collide with commit.
            if (w_issue) begin
                r_entries[r_tail].busy  <= 1'b1;
                r_entries[r_tail].ready <= 1'b0;
                r_entries[r_tail].rd_id <= issue_rd_id;
                r_tail                  <= r_tail + 1'b1;
            end
            case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_1 (
        .i_entries     (r_entries),
        .i_query_tag   (query_tag_1),
        .i_cdb_signal  (cdb_signal),
        .i_cdb_tag     (cdb_tag),
        .i_cdb_value   (cdb_value),
        .o_query_ready (query_ready_1),
        .o_query_value (query_value_1)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_2 (
        .i_entries     (r_entries),
        .i_query_tag   (query_tag_2),
        .i_cdb_signal  (cdb_signal),
        .i_cdb_tag     (cdb_tag),
        .i_cdb_value   (cdb_value),
        .o_query_ready (query_ready_2),
        .o_query_value (query_value_2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic checked
// against an in-order queue model of the in-flight instructions.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        issue_signal;
    logic [31:0] issue_rd_id;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic        cdb_signal;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  query_tag_1;
    logic [3:0]  query_tag_2;
    logic        query_ready_1;
    logic        query_ready_2;
    logic [31:0] query_value_1;
    logic [31:0] query_value_2;
    logic        rob_commit_signal;
    logic [31:0] commit_rd_value;
    logic [3:0]  commit_rd_tag;
    logic [31:0] commit_rd_id;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .issue_signal      (issue_signal),
        .issue_rd_id       (issue_rd_id),
        .issue_tag         (issue_tag),
        .rob_full          (rob_full),
        .cdb_signal        (cdb_signal),
        .cdb_tag           (cdb_tag),
        .cdb_value         (cdb_value),
        .query_tag_1       (query_tag_1),
        .query_tag_2       (query_tag_2),
        .query_ready_1     (query_ready_1),
        .query_ready_2     (query_ready_2),
        .query_value_1     (query_value_1),
        .query_value_2     (query_value_2),
        .rob_commit_signal (rob_commit_signal),
        .commit_rd_value   (commit_rd_value),
        .commit_rd_tag     (commit_rd_tag),
        .commit_rd_id      (commit_rd_id)
    );

    always #5 clk_in = ~clk_in;

    // Model: in-flight instructions in program order; tags assigned round-robin.
    typedef struct {
        int          tag;
        logic [31:0] rd;
        bit          rdy;
        logic [31:0] val;
    } mentry_t;

    mentry_t     mq[$];
    int          m_tail;
    bit          e_sig;
    logic [31:0] e_val;
    logic [31:0] e_id;
    int          e_tag;
    int          n_issued;
    int          total = 0;
    int          bad = 0;

    function automatic int find_tag(int t);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == t) return i;
        return -1;
    endfunction

    function automatic bit exp_ready(int qt);
        int k;
        k = find_tag(qt);
`ifdef ROB_QUERY_BYPASS_EN
        if (cdb_signal && int'(cdb_tag) == qt && k >= 0) return 1'b1;
`endif
        return (k >= 0) && mq[k].rdy;
    endfunction

    function automatic logic [31:0] exp_value(int qt);
        int k;
        k = find_tag(qt);
`ifdef ROB_QUERY_BYPASS_EN
        if (cdb_signal && int'(cdb_tag) == qt && k >= 0) return cdb_value;
`endif
        return (k >= 0) ? mq[k].val : 32'h0;
    endfunction

    task automatic model_edge();
        mentry_t c, n;
        bit      full, do_commit;
        int      k;
        if (!rst_n_in || !rdy_in) return;
        full      = (mq.size() == DEPTH);
        do_commit = (mq.size() > 0) && mq[0].rdy;
        if (do_commit) c = mq[0];
        if (cdb_signal) begin
            k = find_tag(int'(cdb_tag));
            if (k >= 0) begin
                mq[k].rdy = 1'b1;
                mq[k].val = cdb_value;
            end
        end
        if (do_commit) begin
            void'(mq.pop_front());
            e_sig = 1'b1;
            e_val = c.val;
            e_id  = c.rd;
            e_tag = c.tag;
        end else begin
            e_sig = 1'b0;
        end
        if (issue_signal && !full) begin
            n.tag = m_tail;
            n.rd  = issue_rd_id;
            n.rdy = 1'b0;
            n.val = 32'h0;
            mq.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
            n_issued++;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(bit iss, logic [31:0] rd, bit cdb, int ctag, logic [31:0] cval, bit rdy);
        @(negedge clk_in);
        issue_signal = iss;
        issue_rd_id  = rd;
        cdb_signal   = cdb;
        cdb_tag      = 4'(ctag);
        cdb_value    = cval;
        rdy_in       = rdy;
    endtask

    task automatic apply_reset();
        @(negedge clk_in);
        rst_n_in     = 1'b0;
        rdy_in       = 1'b1;
        issue_signal = 1'b0;
        issue_rd_id  = '0;
        cdb_signal   = 1'b0;
        cdb_tag      = '0;
        cdb_value    = '0;
        query_tag_1  = '0;
        query_tag_2  = '0;
        mq.delete();
        m_tail   = 0;
        n_issued = 0;
        e_sig    = 1'b0;
        e_val    = '0;
        e_id     = '0;
        e_tag    = 0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1, 32'd9, 0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 32'h55, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        // tag 0 has just committed; assert reset asynchronously mid-cycle
        #2;
        rst_n_in = 1'b0;
        #1;
        total++;
        if (rob_commit_signal !== 1'b0 || commit_rd_value !== 32'h0 || commit_rd_tag !== 4'h0 || commit_rd_id !== 32'h0) begin
            bad++;
            $display("FAIL reset_commit: sig=%0b val=%h tag=%0d id=%0d, want all 0", rob_commit_signal, commit_rd_value, commit_rd_tag, commit_rd_id);
        end
        total++;
        if (issue_tag !== 4'h0 || rob_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_ptrs: issue_tag=%0d full=%0b, want 0 0", issue_tag, rob_full);
        end
        query_tag_1 = 4'd0;
        #1;
        total++;
        if (query_ready_1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_query: ready=%0b want 0", query_ready_1);
        end
        apply_reset();
    endtask

    task automatic test_single_commit();
        apply_reset();
        drive(1, 32'd5, 0, 0, 0, 1);
        tick();
        total++;
        if (issue_tag !== 4'd1) begin
            bad++;
            $display("FAIL single_issue_tag: got %0d want 1", issue_tag);
        end
        drive(0, 0, 1, 0, 32'hDEADBEEF, 1);
        tick();
        total++;
        if (rob_commit_signal !== 1'b0) begin
            bad++;
            $display("FAIL single_early: pulse=%0b want 0", rob_commit_signal);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (rob_commit_signal !== 1'b1 || commit_rd_tag !== 4'd0 || commit_rd_value !== 32'hDEADBEEF || commit_rd_id !== 32'd5) begin
            bad++;
            $display("FAIL single_commit: sig=%0b tag=%0d val=%h id=%0d want 1 0 deadbeef 5", rob_commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id);
        end
        tick();
        total++;
        if (rob_commit_signal !== 1'b0 || commit_rd_value !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_after: sig=%0b val=%h want 0 deadbeef", rob_commit_signal, commit_rd_value);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'(100 + i), 0, 0, 0, 1);
            tick();
        end
        total++;
        if (rob_full !== 1'b1 || issue_tag !== 4'd0) begin
            bad++;
            $display("FAIL full_set: full=%0b tag=%0d want 1 0", rob_full, issue_tag);
        end
        drive(1, 32'd77, 0, 0, 0, 1);
        tick();
        total++;
        if (rob_full !== 1'b1 || issue_tag !== 4'd0) begin
            bad++;
            $display("FAIL full_drop: full=%0b tag=%0d want 1 0", rob_full, issue_tag);
        end
        drive(0, 0, 1, 0, 32'h1234, 1);
        tick();
        // issue on the commit edge must still be dropped
        drive(1, 32'd88, 0, 0, 0, 1);
        tick();
        total++;
        if (rob_full !== 1'b0 || issue_tag !== 4'd0) begin
            bad++;
            $display("FAIL full_release: full=%0b tag=%0d want 0 0", rob_full, issue_tag);
        end
        total++;
        if (rob_commit_signal !== 1'b1 || commit_rd_tag !== 4'd0 || commit_rd_value !== 32'h1234 || commit_rd_id !== 32'd100) begin
            bad++;
            $display("FAIL full_commit: sig=%0b tag=%0d val=%h id=%0d want 1 0 1234 100", rob_commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id);
        end
    endtask

    task automatic test_out_of_order();
        int exp_tags[4] = '{0, 1, 2, -1};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'(20 + i), 0, 0, 0, 1);
            tick();
        end
        for (int t = 2; t >= 0; t--) begin
            drive(0, 0, 1, t, 32'(32'hC0 + t), 1);
            tick();
            total++;
            if (rob_commit_signal !== 1'b0) begin
                bad++;
                $display("FAIL ooo_hold_%0d: pulse=%0b want 0", t, rob_commit_signal);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (exp_tags[i] < 0) begin
                if (rob_commit_signal !== 1'b0) begin
                    bad++;
                    $display("FAIL ooo_end: pulse=%0b want 0", rob_commit_signal);
                end
            end else if (rob_commit_signal !== 1'b1 || int'(commit_rd_tag) != exp_tags[i] ||
                         commit_rd_value !== 32'(32'hC0 + exp_tags[i]) || commit_rd_id !== 32'(20 + exp_tags[i])) begin
                bad++;
                $display("FAIL ooo_commit_%0d: sig=%0b tag=%0d val=%h id=%0d want tag %0d", i, rob_commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id, exp_tags[i]);
            end
        end
    endtask

    task automatic test_random_wrap();
        int obs_commits = 0;
        int pick, nr;
        int idx[$];
        bit iss, cdb;
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            idx.delete();
            for (int i = 0; i < mq.size(); i++)
                if (!mq[i].rdy) idx.push_back(i);
            nr  = idx.size();
            iss = (c < 60) && ($urandom_range(0, 9) < 7);
            cdb = 1'b0;
            pick = 0;
            if (nr > 0 && $urandom_range(0, 9) < 6) begin
                cdb  = 1'b1;
                pick = mq[idx[$urandom_range(0, nr - 1)]].tag;
            end else if ($urandom_range(0, 3) == 0) begin
                cdb  = 1'b1;
                pick = $urandom_range(0, DEPTH - 1);
            end
            drive(iss, $urandom, cdb, pick, $urandom, 1);
            query_tag_1 = 4'($urandom_range(0, DEPTH - 1));
            query_tag_2 = 4'($urandom_range(0, DEPTH - 1));
            #1;
            total++;
            if (query_ready_1 !== exp_ready(int'(query_tag_1)) || query_ready_2 !== exp_ready(int'(query_tag_2)) ||
                (query_ready_1 && query_value_1 !== exp_value(int'(query_tag_1))) ||
                (query_ready_2 && query_value_2 !== exp_value(int'(query_tag_2)))) begin
                bad++;
                $display("FAIL rand_query c%0d: r1=%0b v1=%h r2=%0b v2=%h want r1=%0b v1=%h r2=%0b v2=%h", c, query_ready_1, query_value_1, query_ready_2, query_value_2,
                         exp_ready(int'(query_tag_1)), exp_value(int'(query_tag_1)), exp_ready(int'(query_tag_2)), exp_value(int'(query_tag_2)));
            end
            tick();
            if (rob_commit_signal === 1'b1) obs_commits++;
            total++;
            if (rob_commit_signal !== e_sig || commit_rd_value !== e_val || int'(commit_rd_tag) != e_tag || commit_rd_id !== e_id ||
                rob_full !== (mq.size() == DEPTH) || int'(issue_tag) != m_tail) begin
                bad++;
                $display("FAIL rand_commit c%0d: sig=%0b val=%h tag=%0d id=%h full=%0b itag=%0d want %0b %h %0d %h %0b %0d", c, rob_commit_signal, commit_rd_value, commit_rd_tag, commit_rd_id,
                         rob_full, issue_tag, e_sig, e_val, e_tag, e_id, (mq.size() == DEPTH), m_tail);
            end
        end
        total++;
        if (mq.size() != 0 || obs_commits != n_issued || n_issued <= DEPTH) begin
            bad++;
            $display("FAIL rand_drain: commits=%0d issued=%0d left=%0d", obs_commits, n_issued, mq.size());
        end
    endtask

    task automatic test_rdy_hold();
        apply_reset();
        drive(1, 32'd7, 0, 0, 0, 1);
        tick();
        drive(1, 32'd8, 0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0, 32'hA0, 1);
        tick();
        drive(0, 0, 1, 1, 32'hA1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'd99, 1, 1, 32'hFF, 0);
            tick();
            total++;
            if (rob_commit_signal !== 1'b1 || commit_rd_tag !== 4'd0 || commit_rd_value !== 32'hA0 || issue_tag !== 4'd2) begin
                bad++;
                $display("FAIL rdy_hold_%0d: sig=%0b tag=%0d val=%h itag=%0d want 1 0 a0 2", i, rob_commit_signal, commit_rd_tag, commit_rd_value, issue_tag);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        total++;
        if (rob_commit_signal !== 1'b1 || commit_rd_tag !== 4'd1 || commit_rd_value !== 32'hA1 || commit_rd_id !== 32'd8) begin
            bad++;
            $display("FAIL rdy_resume: sig=%0b tag=%0d val=%h id=%0d want 1 1 a1 8", rob_commit_signal, commit_rd_tag, commit_rd_value, commit_rd_id);
        end
        tick();
        total++;
        if (rob_commit_signal !== 1'b0 || issue_tag !== 4'd2) begin
            bad++;
            $display("FAIL rdy_single: sig=%0b itag=%0d want 0 2", rob_commit_signal, issue_tag);
        end
    endtask

    task automatic test_query();
        bit exp_same;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(40 + i), 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 1, 3, 32'h42, 1);
        query_tag_1 = 4'd3;
        query_tag_2 = 4'd0;
`ifdef ROB_QUERY_BYPASS_EN
        exp_same = 1'b1;
`else
        exp_same = 1'b0;
`endif
        #1;
        total++;
        if (query_ready_1 !== exp_same || (exp_same && query_value_1 !== 32'h42)) begin
            bad++;
            $display("FAIL query_same_cycle: ready=%0b val=%h want ready=%0b", query_ready_1, query_value_1, exp_same);
        end
        total++;
        if (query_ready_2 !== 1'b0) begin
            bad++;
            $display("FAIL query_other: ready=%0b want 0", query_ready_2);
        end
        tick();
        drive(0, 0, 0, 0, 0, 1);
        #1;
        total++;
        if (query_ready_1 !== 1'b1 || query_value_1 !== 32'h42 || query_ready_2 !== 1'b0) begin
            bad++;
            $display("FAIL query_next: r1=%0b v1=%h r2=%0b want 1 42 0", query_ready_1, query_value_1, query_ready_2);
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        rdy_in       = 1'b1;
        issue_signal = 1'b0;
        issue_rd_id  = '0;
        cdb_signal   = 1'b0;
        cdb_tag      = '0;
        cdb_value    = '0;
        query_tag_1  = '0;
        query_tag_2  = '0;
        test_reset();
        test_single_commit();
        test_full();
        test_out_of_order();
        test_random_wrap();
        test_rdy_hold();
        test_query();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
